// File: rtl/conv_weight_stream_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | conv_weight_stream_ctrl_if                                                 |
// | Control, weight-source, pixel-source and model-side signals of one layer.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface conv_weight_stream_ctrl_if #(
  parameter int IN_CHANNEL = 3
);
  logic                    start;
  logic                    skip_weights;
  logic [31:0]             s_data;
  logic                    s_valid;
  logic                    s_ready;
  logic [8*IN_CHANNEL-1:0] px_data;
  logic                    px_valid;
  logic                    px_ready;
  logic                    fifo_rd_en;
  logic [8*IN_CHANNEL-1:0] i_data;
  logic                    i_valid;
  logic [31:0]             weight_wr_addr;
  logic [31:0]             weight_wr_data;
  logic                    weight_wr_en;
  logic                    busy;
  logic                    weights_done;
  logic                    frame_done;

  modport slave (
    input  start, skip_weights, s_data, s_valid, px_data, px_valid, fifo_rd_en,
    output s_ready, px_ready, i_data, i_valid, weight_wr_addr, weight_wr_data,
           weight_wr_en, busy, weights_done, frame_done
  );

  modport master (
    output start, skip_weights, s_data, s_valid, px_data, px_valid, fifo_rd_en,
    input  s_ready, px_ready, i_data, i_valid, weight_wr_addr, weight_wr_data,
           weight_wr_en, busy, weights_done, frame_done
  );
endinterface

`default_nettype wire

// File: rtl/conv_weight_stream_ctrl.sv
// +----------------------------------------------------------------------------+
// | conv_weight_stream_ctrl                                                    |
// | Loads one conv layer's kernel/bias/coeff words, then gates one pixel frame.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module conv_weight_stream_ctrl #(
  parameter int          KERNEL_WORDS = 432,
  parameter int          BIAS_WORDS   = 16,
  parameter int          COEFF_WORDS  = 1,
  parameter logic [31:0] BASE_ADDR    = 32'd0,
  parameter int          IN_CHANNEL   = 3,
  parameter int          PIXELS       = 65536
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  conv_weight_stream_ctrl_if.slave   bus
);

  localparam int c_TOTAL = KERNEL_WORDS + BIAS_WORDS + COEFF_WORDS;
  localparam int c_W_W   = (c_TOTAL > 0) ? $clog2(c_TOTAL + 1) : 1;
  localparam int c_P_W   = $clog2(PIXELS + 1);

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_LOAD_KERNEL = 3'd1;
  localparam logic [2:0] ST_LOAD_BIAS   = 3'd2;
  localparam logic [2:0] ST_LOAD_COEFF  = 3'd3;
  localparam logic [2:0] ST_STREAM      = 3'd4;
  localparam logic [2:0] ST_DONE        = 3'd5;

  // Empty regions are skipped by resolving each successor state at elaboration.
  localparam logic [2:0] c_AFTER_B = (COEFF_WORDS > 0) ? ST_LOAD_COEFF : ST_STREAM;
  localparam logic [2:0] c_AFTER_K = (BIAS_WORDS > 0)  ? ST_LOAD_BIAS  : c_AFTER_B;
  localparam logic [2:0] c_FIRST   = (KERNEL_WORDS > 0) ? ST_LOAD_KERNEL : c_AFTER_K;

  localparam logic [c_W_W-1:0] c_K_LAST   = c_W_W'(KERNEL_WORDS - 1);
  localparam logic [c_W_W-1:0] c_B_LAST   = c_W_W'(KERNEL_WORDS + BIAS_WORDS - 1);
  localparam logic [c_W_W-1:0] c_ALL_LAST = c_W_W'(c_TOTAL - 1);
  localparam logic [c_P_W-1:0] c_PX_LAST  = c_P_W'(PIXELS - 1);

  logic [2:0]       r_state;
  logic [c_W_W-1:0] r_w;
  logic [c_P_W-1:0] r_px;
  logic             r_wr_en;
  logic [31:0]      r_wr_addr;
  logic [31:0]      r_wr_data;
  logic             r_weights_done;

  logic w_loading;
  logic w_stream;
  logic w_accept;
  logic w_transfer;

  assign w_loading  = (r_state == ST_LOAD_KERNEL) || (r_state == ST_LOAD_BIAS) ||
                      (r_state == ST_LOAD_COEFF);
  assign w_stream   = (r_state == ST_STREAM);
  assign w_accept   = bus.s_valid && w_loading;
  assign w_transfer = bus.px_valid && bus.fifo_rd_en && w_stream;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_w            <= '0;
      r_px           <= '0;
      r_wr_en        <= 1'b0;
      r_wr_addr      <= 32'd0;
      r_wr_data      <= 32'd0;
      r_weights_done <= 1'b0;
    end else begin
      r_wr_en <= w_accept;
      if (w_accept) begin
        r_wr_addr <= BASE_ADDR + 32'(r_w);
        r_wr_data <= (r_state == ST_LOAD_KERNEL) ?
                     {{24{bus.s_data[7]}}, bus.s_data[7:0]} : bus.s_data;
        r_w       <= r_w + c_W_W'(1);
        if (r_w == c_ALL_LAST) begin
          r_weights_done <= 1'b1;
        end
      end

      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_px <= '0;
            if (bus.skip_weights && r_weights_done) begin
              r_state <= ST_STREAM;
            end else begin
              r_w            <= '0;
              r_weights_done <= (c_TOTAL == 0);
              r_state        <= c_FIRST;
            end
          end
        end
        ST_LOAD_KERNEL: if (w_accept && (r_w == c_K_LAST))   r_state <= c_AFTER_K;
        ST_LOAD_BIAS:   if (w_accept && (r_w == c_B_LAST))   r_state <= c_AFTER_B;
        ST_LOAD_COEFF:  if (w_accept && (r_w == c_ALL_LAST)) r_state <= ST_STREAM;
        ST_STREAM: begin
          if (w_transfer) begin
            if (r_px == c_PX_LAST) begin
              r_px    <= '0;
              r_state <= ST_DONE;
            end else begin
              r_px <= r_px + c_P_W'(1);
            end
          end
        end
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.s_ready        = w_loading;
  assign bus.px_ready       = bus.fifo_rd_en && w_stream;
  assign bus.i_valid        = bus.px_valid && w_stream;
  assign bus.i_data         = w_stream ? bus.px_data : '0;
  assign bus.weight_wr_en   = r_wr_en;
  assign bus.weight_wr_addr = r_wr_addr;
  assign bus.weight_wr_data = r_wr_data;
  assign bus.busy           = (r_state != ST_IDLE);
  assign bus.weights_done   = r_weights_done;
  assign bus.frame_done     = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_conv_weight_stream_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_conv_weight_stream_ctrl                                                 |
// | Randomized bench with a phase-level reference model of the layer sequence. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_conv_weight_stream_ctrl;
  localparam int          KW   = 432;
  localparam int          TOT  = 449;
  localparam int          PIX  = 16;
  localparam int          IC   = 3;
  localparam logic [31:0] BASE = 32'd0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_weight_stream_ctrl_if #(.IN_CHANNEL(IC)) bus ();

  conv_weight_stream_ctrl #(
    .KERNEL_WORDS(KW), .BIAS_WORDS(16), .COEFF_WORDS(1), .BASE_ADDR(BASE),
    .IN_CHANNEL(IC), .PIXELS(PIX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: 0 idle, 1 loading (word k of TOT), 2 streaming (pixel p), 3 done
  int          ph, k, p;
  bit          wd, m_en;
  logic [31:0] m_addr, m_data;
  logic [31:0] src_word [TOT];
  logic [23:0] pix [PIX];

  initial begin
    ph = 0; k = 0; p = 0; wd = 0; m_en = 0; m_addr = 0; m_data = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        ph = 0; k = 0; p = 0; wd = 0; m_en = 0; m_addr = 0; m_data = 0;
      end else begin
        m_en = 0;
        case (ph)
          0: if (bus.start) begin
               p = 0;
               if (bus.skip_weights && wd) ph = 2;
               else begin wd = 0; k = 0; ph = 1; end
             end
          1: if (bus.s_valid) begin
               m_en   = 1;
               m_addr = BASE + k;
               m_data = (k < KW) ? {{24{bus.s_data[7]}}, bus.s_data[7:0]} : bus.s_data;
               if (k == TOT - 1) begin ph = 2; wd = 1; end
               k++;
             end
          2: if (bus.px_valid && bus.fifo_rd_en) begin
               p++;
               if (p == PIX) ph = 3;
             end
          default: ph = 0;
        endcase
      end
    end
  end

  int          n_wr = 0, run = 0, last_run = 0, fd_cnt = 0;
  logic [31:0] rise_addr = 32'hDEAD_BEEF;
  bit          prev_en = 0, lit_on = 0;

  initial begin
    forever begin
      @(negedge clk);
      chk("busy",         bus.busy,         32'(ph != 0));
      chk("s_ready",      bus.s_ready,      32'(ph == 1));
      chk("px_ready",     bus.px_ready,     32'((ph == 2) && bus.fifo_rd_en));
      chk("i_valid",      bus.i_valid,      32'((ph == 2) && bus.px_valid));
      chk("i_data",       bus.i_data,       (ph == 2) ? 32'(bus.px_data) : 32'd0);
      chk("frame_done",   bus.frame_done,   32'(ph == 3));
      chk("weights_done", bus.weights_done, 32'(wd));
      chk("wr_en",        bus.weight_wr_en, 32'(m_en));
      chk("wr_addr",      bus.weight_wr_addr, m_addr);
      chk("wr_data",      bus.weight_wr_data, m_data);
      if (ph == 2 && bus.px_valid && bus.fifo_rd_en && p < PIX)
        chk("pixel_order", bus.i_data, 32'(pix[p]));
      if (lit_on && bus.weight_wr_en) begin
        if (bus.weight_wr_addr == 32'd0)   chk("t1_addr0_data",   bus.weight_wr_data, 32'hFFFF_FFFF);
        if (bus.weight_wr_addr == 32'd432) chk("t1_addr432_data", bus.weight_wr_data, 32'h0000_01B0);
        if (bus.weight_wr_addr == 32'd448) begin
          chk("t1_addr448_data", bus.weight_wr_data, 32'h0000_01C0);
          chk("t1_wd_with_last", bus.weights_done, 32'd1);
        end
      end
      if (bus.weight_wr_en) begin
        n_wr++;
        run++;
        if (!prev_en) rise_addr = bus.weight_wr_addr;
      end else if (run > 0) begin
        last_run = run;
        run = 0;
      end
      prev_en = bus.weight_wr_en;
      if (bus.frame_done) fd_cnt++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic skip);
    bus.start = 1'b1;
    bus.skip_weights = skip;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.skip_weights = 1'b0;
  endtask

  // mode 0: back-to-back, 1: every other cycle, 2: random valid
  task automatic load(input int mode, input int abort_at);
    int idx = 0;
    int cyc = 0;
    bit acc;
    while (idx < TOT && cyc < 5000) begin
      case (mode)
        0:       bus.s_valid = 1'b1;
        1:       bus.s_valid = (cyc % 2 == 0);
        default: bus.s_valid = 1'($urandom_range(0, 1));
      endcase
      bus.s_data = src_word[idx];
      @(negedge clk);
      if (abort_at >= 0 && idx == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_busy",    bus.busy,           32'd0);
        chk("async_rst_s_ready", bus.s_ready,        32'd0);
        chk("async_rst_wr_en",   bus.weight_wr_en,   32'd0);
        chk("async_rst_addr",    bus.weight_wr_addr, 32'd0);
        chk("async_rst_data",    bus.weight_wr_data, 32'd0);
        chk("async_rst_wd",      bus.weights_done,   32'd0);
        bus.s_valid = 1'b0;
        return;
      end
      acc = bus.s_valid && bus.s_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      cyc++;
    end
    bus.s_valid = 1'b0;
    if (idx < TOT) chk("load_timeout", 32'(idx), 32'(TOT));
  endtask

  // mode 0: px_valid high, fifo_rd_en 1,0,0 repeating; 1: both random; stress adds start/s_valid noise
  task automatic stream(input int mode, input bit stress);
    int idx = 0;
    int cyc = 0;
    bit acc;
    for (int i = 0; i < PIX; i++) pix[i] = 24'($urandom);
    while (idx < PIX && cyc < 2000) begin
      bus.px_valid   = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.fifo_rd_en = (mode == 0) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      bus.px_data    = pix[idx];
      if (stress) begin
        bus.start   = 1'($urandom_range(0, 1));
        bus.s_valid = 1'b1;
        bus.s_data  = $urandom;
      end
      @(negedge clk);
      acc = bus.px_valid && bus.px_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      cyc++;
    end
    bus.px_valid = 1'b0; bus.fifo_rd_en = 1'b0; bus.start = 1'b0; bus.s_valid = 1'b0;
    if (idx < PIX) chk("stream_timeout", 32'(idx), 32'(PIX));
  endtask

  int n0, fd0;

  initial begin
    bus.start = 0; bus.skip_weights = 0; bus.s_data = 0; bus.s_valid = 0;
    bus.px_data = 0; bus.px_valid = 0; bus.fifo_rd_en = 0;
    cycles(3);
    chk("rst_busy",    bus.busy,         32'd0);
    chk("rst_s_ready", bus.s_ready,      32'd0);
    chk("rst_wd",      bus.weights_done, 32'd0);
    chk("rst_wr_en",   bus.weight_wr_en, 32'd0);
    rst_n = 1'b1;
    cycles(2);

    // Test 1: word k = k, kernel byte 0xFF at k=0, back-to-back
    for (int i = 0; i < TOT; i++) src_word[i] = 32'(i);
    src_word[0] = 32'h0000_00FF;
    lit_on = 1;
    pulse_start(1'b0);
    load(0, -1);
    cycles(2);
    lit_on = 0;
    chk("t1_strobe_run", 32'(last_run), 32'd449);
    chk("t1_wd_after",   bus.weights_done, 32'd1);
    stream(1, 0);
    cycles(3);

    // Test 2: random words, valid every other cycle
    for (int i = 0; i < TOT; i++) src_word[i] = $urandom;
    n0 = n_wr;
    pulse_start(1'b0);
    load(1, -1);
    cycles(2);
    chk("t2_strobes", 32'(n_wr - n0), 32'd449);
    stream(1, 0);
    cycles(3);

    // Test 3: fifo_rd_en 1,0,0 pattern, one frame_done pulse
    fd0 = fd_cnt;
    pulse_start(1'b1);
    stream(0, 0);
    cycles(3);
    chk("t3_frame_done_once", 32'(fd_cnt - fd0), 32'd1);
    chk("t3_idle_after",      bus.busy, 32'd0);

    // Test 4: skip reuses weights; after reset skip is ignored
    n0 = n_wr;
    pulse_start(1'b1);
    stream(1, 0);
    cycles(3);
    chk("t4_skip_no_writes", 32'(n_wr - n0), 32'd0);
    rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
    for (int i = 0; i < TOT; i++) src_word[i] = $urandom;
    n0 = n_wr;
    pulse_start(1'b1);
    load(2, -1);
    cycles(2);
    chk("t4_full_reload", 32'(n_wr - n0), 32'd449);
    stream(1, 0);
    cycles(3);

    // Test 5: reset at w=200, then restart from address 0
    pulse_start(1'b0);
    load(0, 200);
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
    pulse_start(1'b0);
    load(0, -1);
    cycles(2);
    chk("t5_restart_addr", rise_addr, 32'd0);
    chk("t5_restart_run",  32'(last_run), 32'd449);
    stream(1, 0);
    cycles(3);

    // Test 6: start and s_valid noise during STREAM
    n0 = n_wr;
    fd0 = fd_cnt;
    pulse_start(1'b1);
    stream(1, 1);
    cycles(3);
    chk("t6_no_writes",  32'(n_wr - n0), 32'd0);
    chk("t6_frame_done", 32'(fd_cnt - fd0), 32'd1);
    chk("t6_idle_after", bus.busy, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
